ycbcr444_to_422: RTL and testbench

- Downstream neighbour of rgb2YCbCr: consumes its 24-bit YCbCr 4:4:4 AXI4-Stream (1 pixel/clk) and produces 16-bit YCbCr 4:2:2.
- Pixels are paired (even, odd) per line. Cb and Cr are averaged over each pair. Cb rides with the even pixel, Cr with the odd pixel.
- Output feeds the frame-buffer writer; full 1 pixel/clk sustained throughput with back-pressure on both sides.

---
 rtl/ycbcr_pkg.sv | 31 +++
 rtl/ycbcr444_to_422_if.sv | 27 ++
 rtl/axis_pair_buf.sv | 98 +++++++++
 rtl/ycbcr444_to_422.sv | 159 +++++++++++++++
 tb/tb_ycbcr444_to_422.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ycbcr_pkg.sv
// Shared YCbCr definitions: component placement, 4:2:2 word layout and chroma averaging.
package ycbcr_pkg;

    // Component index within a 4:4:4 pixel; bit offset is index * data_width.
    localparam int unsigned Y_LSB     = 0;
    localparam int unsigned CB_LSB    = 1;
    localparam int unsigned CR_LSB    = 2;
    localparam int unsigned PIX_COMPS = 3;

    // 4:2:2 word: luma in the low component, shared chroma in the high one.
    localparam int unsigned WORD_Y_LSB = 0;
    localparam int unsigned WORD_C_LSB = 1;
    localparam int unsigned WORD_COMPS = 2;

    localparam int unsigned AVG_MAX_W = 16;
    localparam int unsigned AVG_SUM_W = AVG_MAX_W + 1;

    typedef enum logic {
        PH_EVEN = 1'b0,
        PH_ODD  = 1'b1
    } phase_e;

    // Round-half-up mean; the extra sum bit makes the result always fit the operand width.
    function automatic logic [AVG_MAX_W-1:0] avg_rnd(input logic [AVG_MAX_W-1:0] a,
                                                     input logic [AVG_MAX_W-1:0] b);
        logic [AVG_SUM_W-1:0] s;
        s = AVG_SUM_W'(a) + AVG_SUM_W'(b) + AVG_SUM_W'(1);
        return s[AVG_SUM_W-1:1];
    endfunction

endpackage

// File: rtl/ycbcr444_to_422_if.sv
// Stream bundle for the 4:4:4 -> 4:2:2 converter: r* is the 4:4:4 input, t* the 4:2:2 output.
interface ycbcr444_to_422_if
    import ycbcr_pkg::*;
#(
    parameter int unsigned DW = 8
);
    logic [PIX_COMPS*DW-1:0]  rdata;
    logic                     rvalid;
    logic                     rready;
    logic                     rlast;
    logic                     ruser;
    logic [WORD_COMPS*DW-1:0] tdata;
    logic                     tvalid;
    logic                     tready;
    logic                     tlast;
    logic                     tuser;

    modport master (
        output rdata, rvalid, rlast, ruser, tready,
        input  rready, tdata, tvalid, tlast, tuser
    );

    modport slave (
        input  rdata, rvalid, rlast, ruser, tready,
        output rready, tdata, tvalid, tlast, tuser
    );
endinterface

// File: rtl/axis_pair_buf.sv
// Two-entry output FIFO with registered AXI4-Stream outputs; accepts one or two words per cycle.
module axis_pair_buf #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push1,
    input  logic         push2,
    input  logic [W-1:0] word0,
    input  logic         word0_last,
    input  logic         word0_user,
    input  logic [W-1:0] word1,
    input  logic         word1_last,
    input  logic         word1_user,
    output logic [1:0]   count,
    input  logic         tready,
    output logic         tvalid,
    output logic [W-1:0] tdata,
    output logic         tlast,
    output logic         tuser
);
    localparam int unsigned CNT_W = 2;

    logic [W-1:0]     d0_q, d0_d, d1_q, d1_d;
    logic             l0_q, l0_d, l1_q, l1_d;
    logic             u0_q, u0_d, u1_q, u1_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             tvalid_q, tvalid_d;
    logic             pop_c;
    logic [CNT_W-1:0] base_c;

    assign pop_c = tvalid_q & tready;

    // Entry 0 is the output register; entry 1 shifts into it on a pop, new words append behind.
    always_comb begin
        d0_d     = d0_q;
        l0_d     = l0_q;
        u0_d     = u0_q;
        d1_d     = d1_q;
        l1_d     = l1_q;
        u1_d     = u1_q;
        base_c   = count_q - CNT_W'(pop_c);
        count_d  = base_c + CNT_W'(push1) + (push2 ? CNT_W'(2) : CNT_W'(0));
        if (base_c == CNT_W'(0)) begin
            if (push1 || push2) begin
                d0_d = word0;
                l0_d = word0_last;
                u0_d = word0_user;
            end
            if (push2) begin
                d1_d = word1;
                l1_d = word1_last;
                u1_d = word1_user;
            end
        end else if (base_c == CNT_W'(1)) begin
            if (pop_c) begin
                d0_d = d1_q;
                l0_d = l1_q;
                u0_d = u1_q;
            end
            if (push1) begin
                d1_d = word0;
                l1_d = word0_last;
                u1_d = word0_user;
            end
        end
        tvalid_d = (count_d != CNT_W'(0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d0_q     <= '0;
            l0_q     <= 1'b0;
            u0_q     <= 1'b0;
            d1_q     <= '0;
            l1_q     <= 1'b0;
            u1_q     <= 1'b0;
            count_q  <= '0;
            tvalid_q <= 1'b0;
        end else begin
            d0_q     <= d0_d;
            l0_q     <= l0_d;
            u0_q     <= u0_d;
            d1_q     <= d1_d;
            l1_q     <= l1_d;
            u1_q     <= u1_d;
            count_q  <= count_d;
            tvalid_q <= tvalid_d;
        end
    end

    assign count  = count_q;
    assign tvalid = tvalid_q;
    assign tdata  = d0_q;
    assign tlast  = l0_q;
    assign tuser  = u0_q;

endmodule

// File: rtl/ycbcr444_to_422.sv
// YCbCr 4:4:4 -> 4:2:2 converter: pairs pixels per line, Cb rides the even word, Cr the odd word.
module ycbcr444_to_422
    import ycbcr_pkg::*;
#(
    parameter int unsigned data_width = 8,
    parameter bit          avg_en     = 1'b1
) (
    input  logic             clk_in,
    input  logic             reset,
    ycbcr444_to_422_if.slave bus
);
    localparam int unsigned DW = data_width;
    localparam int unsigned WW = WORD_COMPS * DW;

    logic [DW-1:0] y_in, cb_in, cr_in;
    logic [DW-1:0] h_y_q, h_y_d, h_cb_q, h_cb_d, h_cr_q, h_cr_d;
    logic          h_user_q, h_user_d;
    phase_e        phase_q, phase_d;
    logic          run_q, run_d;

    logic [DW-1:0] cb_avg_c, cr_avg_c;
    logic          push1_c, push2_c;
    logic [WW-1:0] w0_c, w1_c;
    logic          w0_last_c, w0_user_c, w1_last_c, w1_user_c;
    logic [1:0]    count_c;
    logic          pop_c, room_c, rready_c, acc_c;
    logic          tvalid_w, tlast_w, tuser_w;
    logic [WW-1:0] tdata_w;

    assign y_in  = bus.rdata[Y_LSB*DW  +: DW];
    assign cb_in = bus.rdata[CB_LSB*DW +: DW];
    assign cr_in = bus.rdata[CR_LSB*DW +: DW];

    assign cb_avg_c = avg_en ? DW'(avg_rnd(AVG_MAX_W'(h_cb_q), AVG_MAX_W'(cb_in))) : h_cb_q;
    assign cr_avg_c = avg_en ? DW'(avg_rnd(AVG_MAX_W'(h_cr_q), AVG_MAX_W'(cr_in))) : cr_in;

    assign pop_c = tvalid_w & bus.tready;

    // An even pixel may push at most one word, an odd pixel two; admit only when P has room.
    always_comb begin
        room_c = 1'b0;
        if (phase_q == PH_EVEN) begin
            room_c = (count_c <= 2'd1) || ((count_c == 2'd2) && pop_c);
        end else begin
            room_c = (count_c == 2'd0) || ((count_c == 2'd1) && pop_c);
        end
    end

    assign rready_c   = run_q & ~reset & room_c;
    assign acc_c      = bus.rvalid & rready_c;
    assign bus.rready = rready_c;

    always_comb begin
        phase_d   = phase_q;
        h_y_d     = h_y_q;
        h_cb_d    = h_cb_q;
        h_cr_d    = h_cr_q;
        h_user_d  = h_user_q;
        run_d     = 1'b1;
        push1_c   = 1'b0;
        push2_c   = 1'b0;
        w0_c      = '0;
        w1_c      = '0;
        w0_last_c = 1'b0;
        w0_user_c = 1'b0;
        w1_last_c = 1'b0;
        w1_user_c = 1'b0;
        if (acc_c) begin
            if (phase_q == PH_EVEN) begin
                if (bus.rlast) begin
                    push1_c                   = 1'b1;
                    w0_c[WORD_Y_LSB*DW +: DW] = y_in;
                    w0_c[WORD_C_LSB*DW +: DW] = cb_in;
                    w0_last_c                 = 1'b1;
                    w0_user_c                 = bus.ruser;
                end else begin
                    h_y_d    = y_in;
                    h_cb_d   = cb_in;
                    h_cr_d   = cr_in;
                    h_user_d = bus.ruser;
                    phase_d  = PH_ODD;
                end
            end else if (bus.ruser) begin
                // Frame restart mid-pair: the held pixel leaves alone, the new one becomes even.
                w0_c[WORD_Y_LSB*DW +: DW] = h_y_q;
                w0_c[WORD_C_LSB*DW +: DW] = h_cb_q;
                w0_user_c                 = h_user_q;
                if (bus.rlast) begin
                    push2_c                   = 1'b1;
                    w1_c[WORD_Y_LSB*DW +: DW] = y_in;
                    w1_c[WORD_C_LSB*DW +: DW] = cb_in;
                    w1_last_c                 = 1'b1;
                    w1_user_c                 = 1'b1;
                    phase_d                   = PH_EVEN;
                end else begin
                    push1_c  = 1'b1;
                    h_y_d    = y_in;
                    h_cb_d   = cb_in;
                    h_cr_d   = cr_in;
                    h_user_d = 1'b1;
                end
            end else begin
                push2_c                   = 1'b1;
                w0_c[WORD_Y_LSB*DW +: DW] = h_y_q;
                w0_c[WORD_C_LSB*DW +: DW] = cb_avg_c;
                w0_user_c                 = h_user_q;
                w1_c[WORD_Y_LSB*DW +: DW] = y_in;
                w1_c[WORD_C_LSB*DW +: DW] = cr_avg_c;
                w1_last_c                 = bus.rlast;
                phase_d                   = PH_EVEN;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            phase_q  <= PH_EVEN;
            h_y_q    <= '0;
            h_cb_q   <= '0;
            h_cr_q   <= '0;
            h_user_q <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            h_y_q    <= h_y_d;
            h_cb_q   <= h_cb_d;
            h_cr_q   <= h_cr_d;
            h_user_q <= h_user_d;
            run_q    <= run_d;
        end
    end

    axis_pair_buf #(
        .W (WW)
    ) u_pair_buf (
        .clk        (clk_in),
        .reset      (reset),
        .push1      (push1_c),
        .push2      (push2_c),
        .word0      (w0_c),
        .word0_last (w0_last_c),
        .word0_user (w0_user_c),
        .word1      (w1_c),
        .word1_last (w1_last_c),
        .word1_user (w1_user_c),
        .count      (count_c),
        .tready     (bus.tready),
        .tvalid     (tvalid_w),
        .tdata      (tdata_w),
        .tlast      (tlast_w),
        .tuser      (tuser_w)
    );

    assign bus.tvalid = tvalid_w;
    assign bus.tdata  = tdata_w;
    assign bus.tlast  = tlast_w;
    assign bus.tuser  = tuser_w;

endmodule

// File: tb/tb_ycbcr444_to_422.sv
// Bench for ycbcr444_to_422: averaging and decimating instances share one input stream and are
// scored against a pixel-level reference model.
module tb_ycbcr444_to_422;

    localparam int unsigned DW = 8;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] cb;
        logic [7:0] cr;
        logic       last;
        logic       user;
    } pix_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ycbcr444_to_422_if #(.DW(DW)) bus_a ();
    ycbcr444_to_422_if #(.DW(DW)) bus_d ();

    assign bus_d.rdata  = bus_a.rdata;
    assign bus_d.rvalid = bus_a.rvalid;
    assign bus_d.rlast  = bus_a.rlast;
    assign bus_d.ruser  = bus_a.ruser;
    assign bus_d.tready = bus_a.tready;

    ycbcr444_to_422 #(.data_width(DW), .avg_en(1'b1)) dut_a (
        .clk_in (clk),
        .reset  (reset),
        .bus    (bus_a)
    );

    ycbcr444_to_422 #(.data_width(DW), .avg_en(1'b0)) dut_d (
        .clk_in (clk),
        .reset  (reset),
        .bus    (bus_d)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          tr_mode = 1;
    pix_t        src_q[$];
    logic [17:0] exp_a[$];
    logic [17:0] exp_d[$];
    bit          have_even = 1'b0;
    pix_t        ev;
    bit          thr_chk = 1'b0;
    bit          lat_arm = 1'b0;
    bit          lat_wait = 1'b0;
    int          acc_cyc = 0;
    bit          prev_stall = 1'b0;
    logic [17:0] prev_word = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
        int s;
        s = (int'(a) + int'(b) + 1) / 2;
        return 8'(s);
    endfunction

    task automatic emit_both(input logic [17:0] w);
        exp_a.push_back(w);
        exp_d.push_back(w);
    endtask

    // Reference: pair pixels in order; restart or line end may leave a pixel alone.
    task automatic model_accept(input pix_t p);
        if (!have_even) begin
            if (p.last) emit_both({p.user, 1'b1, p.cb, p.y});
            else begin
                ev        = p;
                have_even = 1'b1;
            end
        end else if (p.user) begin
            emit_both({ev.user, 1'b0, ev.cb, ev.y});
            if (p.last) begin
                emit_both({1'b1, 1'b1, p.cb, p.y});
                have_even = 1'b0;
            end else begin
                ev = p;
            end
        end else begin
            exp_a.push_back({ev.user, 1'b0, avg8(ev.cb, p.cb), ev.y});
            exp_a.push_back({1'b0, p.last, avg8(ev.cr, p.cr), p.y});
            exp_d.push_back({ev.user, 1'b0, ev.cb, ev.y});
            exp_d.push_back({1'b0, p.last, p.cr, p.y});
            have_even = 1'b0;
        end
    endtask

    task automatic monitor();
        logic [17:0] wa;
        logic [17:0] wd;
        pix_t        p;
        wa = {bus_a.tuser, bus_a.tlast, bus_a.tdata};
        wd = {bus_d.tuser, bus_d.tlast, bus_d.tdata};
        if (reset) begin
            exp_a.delete();
            exp_d.delete();
            have_even  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (bus_a.rvalid && bus_a.rready && src_q.size() != 0) begin
                p = src_q.pop_front();
                model_accept(p);
                if (lat_arm) begin
                    acc_cyc  = cyc;
                    lat_arm  = 1'b0;
                    lat_wait = 1'b1;
                end
            end
            if (thr_chk && bus_a.rvalid) chk("rready_thru", 32'(bus_a.rready), 32'(1));
            if (prev_stall) begin
                chk("stall_tvalid", 32'(bus_a.tvalid), 32'(1));
                chk("stall_word", 32'(wa), 32'(prev_word));
            end
            prev_stall = bus_a.tvalid && !bus_a.tready;
            prev_word  = wa;
            if (bus_a.tvalid && lat_wait) begin
                chk("latency", 32'(cyc - acc_cyc), 32'(2));
                lat_wait = 1'b0;
            end
            if (bus_a.tvalid && bus_a.tready) begin
                chk("pending_a", 32'(exp_a.size() != 0), 32'(1));
                if (exp_a.size() != 0) chk("word_avg", 32'(wa), 32'(exp_a.pop_front()));
            end
            if (bus_d.tvalid && bus_d.tready) begin
                chk("pending_d", 32'(exp_d.size() != 0), 32'(1));
                if (exp_d.size() != 0) chk("word_dec", 32'(wd), 32'(exp_d.pop_front()));
            end
        end
    endtask

    task automatic drive();
        pix_t p;
        case (tr_mode)
            0:       bus_a.tready = 1'b0;
            1:       bus_a.tready = 1'b1;
            default: bus_a.tready = ((cyc % 2) == 0);
        endcase
        if (src_q.size() != 0 && !reset) begin
            p            = src_q[0];
            bus_a.rvalid = 1'b1;
            bus_a.rdata  = {p.cr, p.cb, p.y};
            bus_a.rlast  = p.last;
            bus_a.ruser  = p.user;
        end else begin
            bus_a.rvalid = 1'b0;
            bus_a.rdata  = '0;
            bus_a.rlast  = 1'b0;
            bus_a.ruser  = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
        drive();
    endtask

    task automatic put(input int y, input int cb, input int cr, input bit last, input bit user);
        pix_t p;
        p.y    = 8'(y);
        p.cb   = 8'(cb);
        p.cr   = 8'(cr);
        p.last = last;
        p.user = user;
        src_q.push_back(p);
    endtask

    task automatic wait_drain(input int maxc);
        int n;
        n = 0;
        while (n < maxc && (src_q.size() != 0 || exp_a.size() != 0 || exp_d.size() != 0)) begin
            tick();
            n++;
        end
        chk("drain_left", 32'(src_q.size() + exp_a.size() + exp_d.size()), 32'(0));
        repeat (3) tick();
    endtask

    initial begin
        int left;
        int len;
        bit first;
        reset = 1'b1;
        drive();
        repeat (3) tick();
        chk("rst_tvalid", 32'(bus_a.tvalid), 32'(0));
        chk("rst_tdata", 32'(bus_a.tdata), 32'(0));
        chk("rst_tlast", 32'(bus_a.tlast), 32'(0));
        chk("rst_tuser", 32'(bus_a.tuser), 32'(0));
        chk("rst_rready", 32'(bus_a.rready), 32'(0));
        reset = 1'b0;
        #1;
        chk("rready_after_rst", 32'(bus_a.rready), 32'(0));
        tick();
        chk("rready_rise", 32'(bus_a.rready), 32'(1));

        // Four-pixel line, full rate; first output two clocks after first input.
        thr_chk = 1'b1;
        lat_arm = 1'b1;
        put(10, 20, 30, 0, 1);
        put(11, 40, 50, 0, 0);
        put(12, 100, 200, 0, 0);
        put(13, 101, 201, 1, 0);
        wait_drain(50);
        chk("latency_seen", 32'({lat_arm, lat_wait}), 32'(0));

        // Averaging extremes.
        put(0, 255, 0, 0, 1);
        put(1, 255, 1, 1, 0);
        wait_drain(50);

        // Odd-length line, then a pair that must start in the even phase.
        put(1, 2, 3, 0, 1);
        put(4, 5, 6, 0, 0);
        put(5, 77, 88, 1, 0);
        put(7, 8, 9, 0, 0);
        put(10, 11, 12, 1, 0);
        wait_drain(50);

        // One-pixel frame: start and end on the same word.
        put(60, 61, 62, 1, 1);
        wait_drain(50);

        // Frame restart on pixel index 1.
        put(20, 21, 22, 0, 1);
        put(30, 31, 32, 0, 1);
        put(40, 41, 42, 0, 0);
        put(50, 51, 52, 1, 0);
        wait_drain(50);
        thr_chk = 1'b0;

        // Random lines under alternating back-pressure.
        tr_mode = 2;
        left    = 64;
        first   = 1'b1;
        while (left > 0) begin
            len = int'($urandom_range(1, 9));
            if (len > left) len = left;
            for (int i = 0; i < len; i++) begin
                put(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 255)), (i == len - 1), first && (i == 0));
            end
            first = 1'b0;
            left  = left - len;
        end
        wait_drain(600);

        // Reset while holding a pixel with buffered output under full back-pressure.
        tr_mode = 0;
        put(70, 71, 72, 0, 1);
        put(80, 81, 82, 0, 1);
        put(90, 91, 92, 0, 0);
        repeat (6) tick();
        chk("blocked_rready", 32'(bus_a.rready), 32'(0));
        chk("blocked_tvalid", 32'(bus_a.tvalid), 32'(1));
        reset = 1'b1;
        src_q.delete();
        bus_a.rvalid = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        chk("rst2_tvalid", 32'(bus_a.tvalid), 32'(0));
        chk("rst2_rready", 32'(bus_a.rready), 32'(0));
        tr_mode = 1;
        put(100, 110, 120, 0, 1);
        put(101, 111, 121, 1, 0);
        wait_drain(50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
